conway_gen_scheduler: RTL and testbench

Generation scheduler for the Conway accelerator. Owns the ping-pong buffer roles: chooses which tmemory bank is the accelerator's source, and launches one generation per programmed number of VGA frames. Swaps the displayed bank only at vertical blank, so the VGA path never scans a half-written generation. Also exposes the host register window used to seed the displayed bank and to run, step and stop the simulation.

---
 rtl/conway_pkg.sv | 39 +++
 rtl/conway_sched_wdog.sv | 29 ++
 rtl/conway_gen_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_conway_gen_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared definitions for the Conway generation scheduler: FSM state
// encoding, host register map, CTRL/STATUS bit positions and array geometry.
package conway_pkg;

  localparam int ROW_WORDS = 64;
  localparam int ADDR_W    = 16;
  localparam int WORD_W    = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_VB   = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_COMPUTE   = 3'd3,
    ST_SWAP_WAIT = 3'd4
  } sched_state_t;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_GEN_LIMIT = 3'd2;
  localparam logic [2:0] REG_GEN_COUNT = 3'd3;
  localparam logic [2:0] REG_FRAME_DIV = 3'd4;
  localparam logic [2:0] REG_SEED_ADDR = 3'd5;
  localparam logic [2:0] REG_SEED_DATA = 3'd6;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_STEP   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STS_DISP      = 3;
  localparam int STS_SEED_ERR  = 4;
  localparam int STS_TIMEOUT   = 5;
  localparam int STS_LIMIT_HIT = 6;

  // A frame divider of zero behaves as one vblank per generation.
  function automatic logic [7:0] frame_div_eff(input logic [7:0] fd);
    return (fd == 8'd0) ? 8'd1 : fd;
  endfunction

endpackage

// File: rtl/conway_sched_wdog.sv
// Compute watchdog: counts COMPUTE cycles since the last launch and flags
// expiry on the cycle whose increment would bring the counter to all-ones,
// i.e. 2^WDOG_W - 1 cycles after the launch cycle.
module conway_sched_wdog #(
  parameter int WDOG_W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  logic [WDOG_W-1:0] cnt;

  // Restart on every launch, advance only while the accelerator is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = count_en && (cnt == {{(WDOG_W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/conway_gen_scheduler.sv
// Conway generation scheduler: owns the ping-pong bank roles, paces
// generations against vertical blank, and exposes the host register window.
// Optional compute watchdog enabled by defining CONWAY_SCHED_WDOG_EN.
module conway_gen_scheduler #(
  parameter int ADDR_W = conway_pkg::ADDR_W,
  parameter int WORD_W = conway_pkg::WORD_W,
  parameter int WDOG_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic              vblank,
  output logic              accel_start,
  output logic              accel_src_sel,
  input  logic              accel_done,
  output logic              accel_clear,
  output logic              disp_sel,
  output logic              seed_wren,
  output logic              seed_sel,
  output logic [ADDR_W-1:0] seed_addr,
  output logic [WORD_W-1:0] seed_data
);

  import conway_pkg::*;

  sched_state_t      state;
  logic [7:0]        vb_cnt;
  logic              step_flag;
  logic [31:0]       gen_count;
  logic [31:0]       gen_count_inc;

  logic              run;
  logic              irq_en;
  logic              limit_hit;
  logic              seed_err;
  logic              timeout;
  logic [31:0]       gen_limit;
  logic [7:0]        frame_div;
  logic [ADDR_W-1:0] seed_ptr;

  logic bus_wr;
  logic wr_ctrl, wr_status, wr_gen_limit, wr_frame_div, wr_seed_addr, wr_seed_data;
  logic step_req;
  logic run_next;
  logic limit_fire;
  logic timeout_fire;
  logic wdog_expire;

  assign bus_wr       = chipselect & write;
  assign wr_ctrl      = bus_wr && (address == REG_CTRL);
  assign wr_status    = bus_wr && (address == REG_STATUS);
  assign wr_gen_limit = bus_wr && (address == REG_GEN_LIMIT);
  assign wr_frame_div = bus_wr && (address == REG_FRAME_DIV);
  assign wr_seed_addr = bus_wr && (address == REG_SEED_ADDR);
  assign wr_seed_data = bus_wr && (address == REG_SEED_DATA);
  assign step_req     = wr_ctrl && writedata[CTRL_STEP];

  assign gen_count_inc = gen_count + 32'd1;
  assign limit_fire    = (state == ST_SWAP_WAIT) && vblank && (gen_limit != 32'd0) &&
                         (gen_count_inc == gen_limit);
  // A completion in the same cycle as expiry wins: the generation is kept.
  assign timeout_fire  = (state == ST_COMPUTE) && !accel_done && wdog_expire;
  assign irq           = irq_en & (limit_hit | timeout);

  // RUN as it will be after this cycle, so a same-cycle CTRL write is honoured.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned; an unassigned path infers a latch.
    run_next = run;
    if (wr_ctrl) run_next = writedata[CTRL_RUN];
  end

`ifdef CONWAY_SCHED_WDOG_EN
  conway_sched_wdog #(
    .WDOG_W   (WDOG_W)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == ST_LAUNCH),
    .count_en (state == ST_COMPUTE),
    .expire   (wdog_expire)
  );
  assign accel_clear = timeout_fire;
`else
  localparam int unused_wdog_w = WDOG_W;
  assign wdog_expire = 1'b0;
  assign accel_clear = 1'b0;
`endif

  // Generation sequencer: pace launches by vblank, swap banks only at vblank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      vb_cnt        <= 8'd0;
      step_flag     <= 1'b0;
      accel_start   <= 1'b0;
      accel_src_sel <= 1'b0;
      disp_sel      <= 1'b0;
      gen_count     <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every branch
      // below reads the pre-edge value of state, vb_cnt and disp_sel.
      accel_start   <= 1'b0;
      accel_src_sel <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (run_next || step_req) begin
            state     <= ST_WAIT_VB;
            vb_cnt    <= frame_div_eff(frame_div);
            step_flag <= step_req;
          end
        end
        ST_WAIT_VB: begin
          if (vb_cnt <= 8'd1) begin
            state         <= ST_LAUNCH;
            accel_start   <= 1'b1;
            accel_src_sel <= disp_sel;
          end else if (vblank) begin
            vb_cnt <= vb_cnt - 8'd1;
          end
        end
        ST_LAUNCH: begin
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          // A vblank coincident with done is deliberately not used for the swap.
          if (accel_done) begin
            state <= ST_SWAP_WAIT;
          end else if (timeout_fire) begin
            state <= ST_IDLE;
          end
        end
        ST_SWAP_WAIT: begin
          if (vblank) begin
            disp_sel  <= ~disp_sel;
            gen_count <= gen_count_inc;
            vb_cnt    <= frame_div_eff(frame_div);
            if (limit_fire || step_flag || !run_next) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT_VB;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Host-writable registers, sticky status flags and the seed write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run       <= 1'b0;
      irq_en    <= 1'b0;
      limit_hit <= 1'b0;
      seed_err  <= 1'b0;
      timeout   <= 1'b0;
      gen_limit <= 32'd0;
      frame_div <= 8'd0;
      seed_ptr  <= '0;
      seed_wren <= 1'b0;
      seed_sel  <= 1'b0;
      seed_addr <= '0;
      seed_data <= '0;
    end else begin
      seed_wren <= 1'b0;

      if (wr_ctrl) begin
        run    <= writedata[CTRL_RUN];
        irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (limit_fire || timeout_fire) run <= 1'b0;

      // Any STATUS write clears the sticky flags; a same-cycle event still sets.
      if (wr_status) begin
        seed_err  <= 1'b0;
        timeout   <= 1'b0;
        limit_hit <= 1'b0;
      end
      if (limit_fire)   limit_hit <= 1'b1;
      if (timeout_fire) timeout   <= 1'b1;

      if (wr_gen_limit) gen_limit <= writedata;
      if (wr_frame_div) frame_div <= writedata[7:0];
      if (wr_seed_addr) seed_ptr  <= writedata[ADDR_W-1:0];

      // Seeding is only safe while no generation can touch the displayed bank.
      if (wr_seed_data) begin
        if (state == ST_IDLE) begin
          seed_wren <= 1'b1;
          seed_sel  <= disp_sel;
          seed_addr <= seed_ptr;
          seed_data <= writedata[WORD_W-1:0];
          seed_ptr  <= seed_ptr + 1'b1;
        end else begin
          seed_err <= 1'b1;
        end
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else if (chipselect && read) begin
      case (address)
        REG_CTRL:      readdata <= {29'd0, irq_en, 1'b0, run};
        REG_STATUS:    readdata <= {25'd0, limit_hit, timeout, seed_err, disp_sel, state};
        REG_GEN_LIMIT: readdata <= gen_limit;
        REG_GEN_COUNT: readdata <= gen_count;
        REG_FRAME_DIV: readdata <= {24'd0, frame_div};
        REG_SEED_ADDR: readdata <= 32'(seed_ptr);
        default:       readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_conway_gen_scheduler.sv
// Self-checking bench for conway_gen_scheduler. Expected launches, bank
// toggles and seed writes are queued when stimulus is driven and compared
// when the DUT produces them. Watchdog scenario runs when
// CONWAY_SCHED_WDOG_EN is defined.
module tb_conway_gen_scheduler;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 20;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } seed_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              chipselect = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [2:0]        address = 3'd0;
  logic [31:0]       writedata = 32'd0;
  logic [31:0]       readdata;
  logic              irq;
  logic              vblank;
  logic              accel_start;
  logic              accel_src_sel;
  logic              accel_done;
  logic              accel_clear;
  logic              disp_sel;
  logic              seed_wren;
  logic              seed_sel;
  logic [ADDR_W-1:0] seed_addr;
  logic [WORD_W-1:0] seed_data;

  logic vb_auto = 1'b0, vb_man = 1'b0;
  logic done_model = 1'b0, done_man = 1'b0;
  assign vblank     = vb_auto | vb_man;
  assign accel_done = done_model | done_man;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int vb_period = 0;
  int done_delay = 0;
  int acc_cnt = 0;
  int starts_seen = 0;
  int start_cyc = 0;
  int clears_seen = 0;
  int clear_cyc = 0;
  logic prev_disp = 1'b0;
  logic vb_prev = 1'b0;

  logic  src_q[$];
  logic  disp_q[$];
  seed_t seed_q[$];

  conway_gen_scheduler #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .WDOG_W (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .write         (write),
    .read          (read),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq),
    .vblank        (vblank),
    .accel_start   (accel_start),
    .accel_src_sel (accel_src_sel),
    .accel_done    (accel_done),
    .accel_clear   (accel_clear),
    .disp_sel      (disp_sel),
    .seed_wren     (seed_wren),
    .seed_sel      (seed_sel),
    .seed_addr     (seed_addr),
    .seed_data     (seed_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Periodic vblank source.
  initial forever begin
    @(posedge clk); #1;
    vb_auto = (vb_period != 0) && ((cyc % vb_period) == vb_period - 1);
  end

  // Accelerator model: done pulse done_delay cycles after accel_start.
  initial forever begin
    @(posedge clk); #1;
    done_model = 1'b0;
    if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) done_model = 1'b1;
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_disp = disp_sel;
      vb_prev   = 1'b0;
    end else begin
      if (accel_start) begin
        starts_seen++;
        start_cyc = cyc;
        if (done_delay > 0) acc_cnt = done_delay;
        if (src_q.size() == 0) check("unexpected accel_start", 32'd1, 32'd0);
        else check("accel_src_sel", 32'(accel_src_sel), 32'(src_q.pop_front()));
      end
      if (seed_wren) begin
        if (seed_q.size() == 0) check("unexpected seed_wren", 32'd1, 32'd0);
        else begin
          seed_t e;
          e = seed_q.pop_front();
          check("seed_sel", 32'(seed_sel), 32'(e.sel));
          check("seed_addr", 32'(seed_addr), 32'(e.addr));
          check("seed_data", 32'(seed_data), 32'(e.data));
        end
      end
      if (accel_clear) begin
        clears_seen++;
        clear_cyc = cyc;
      end
      if (disp_sel !== prev_disp) begin
        check("disp toggle follows vblank", 32'(vb_prev), 32'd1);
        if (disp_q.size() == 0) check("unexpected disp toggle", 32'd1, 32'd0);
        else check("disp_sel", 32'(disp_sel), 32'(disp_q.pop_front()));
      end
      prev_disp = disp_sel;
      vb_prev   = vblank;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic pulse_vb();
    @(posedge clk); #1; vb_man = 1'b1;
    @(posedge clk); #1; vb_man = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; done_man = 1'b1;
    @(posedge clk); #1; done_man = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (starts_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(starts_seen), 32'(target));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1; reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int base;

    // Reset values.
    wait_cycles(3);
    reset = 1'b0;
    check("rst accel_start", 32'(accel_start), 32'd0);
    check("rst disp_sel", 32'(disp_sel), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst seed_wren", 32'(seed_wren), 32'd0);
    check("rst accel_clear", 32'(accel_clear), 32'd0);
    check("rst readdata", readdata, 32'd0);
    rd_check("rst STATUS", 3'd1, 32'h0);
    rd_check("rst CTRL", 3'd0, 32'h0);
    rd_check("rst GEN_COUNT", 3'd3, 32'h0);

    // Seeding in IDLE with address wrap.
    bus_write(3'd5, 32'h0000_FFFF);
    seed_q.push_back('{sel: 1'b0, addr: 16'hFFFF, data: 20'hABCDE});
    seed_q.push_back('{sel: 1'b0, addr: 16'h0000, data: 20'h12345});
    bus_write(3'd6, 32'h000A_BCDE);
    bus_write(3'd6, 32'h0001_2345);
    wait_cycles(3);
    check("seed queue drained", 32'(seed_q.size()), 32'd0);
    rd_check("SEED_ADDR after wrap", 3'd5, 32'h1);
    rd_check("STATUS no seed err", 3'd1, 32'h0);

    // Free-running with generation limit 3.
    vb_period  = 2000;
    done_delay = 100;
    bus_write(3'd4, 32'd1);
    bus_write(3'd2, 32'd3);
    src_q.push_back(1'b0); src_q.push_back(1'b1); src_q.push_back(1'b0);
    disp_q.push_back(1'b1); disp_q.push_back(1'b0); disp_q.push_back(1'b1);
    bus_write(3'd0, 32'h5);
    @(negedge clk);
    check("launch latency +1", 32'(accel_start), 32'd0);
    @(negedge clk);
    check("launch latency +2", 32'(accel_start), 32'd1);
    base = 0;
    while (disp_q.size() != 0 && base < 9000) begin
      @(negedge clk);
      base++;
    end
    check("limit toggles pending", 32'(disp_q.size()), 32'd0);
    wait_cycles(5);
    check("limit src pending", 32'(src_q.size()), 32'd0);
    rd_check("limit GEN_COUNT", 3'd3, 32'd3);
    rd_check("limit CTRL", 3'd0, 32'h4);
    rd_check("limit STATUS", 3'd1, 32'h48);
    check("limit irq", 32'(irq), 32'd1);
    bus_write(3'd1, 32'h0);
    rd_check("STATUS cleared", 3'd1, 32'h08);
    check("irq cleared", 32'(irq), 32'd0);
    vb_period = 0;
    wait_cycles(2);
    apply_reset();

    // Single step with FRAME_DIV=4; a second STEP during COMPUTE is ignored.
    done_delay = 30;
    bus_write(3'd4, 32'd4);
    base = starts_seen;
    src_q.push_back(1'b0);
    bus_write(3'd0, 32'h2);
    pulse_vb(); wait_cycles(10);
    pulse_vb(); wait_cycles(10);
    check("no launch before 3rd vblank", 32'(starts_seen), 32'(base));
    pulse_vb();
    wait_starts("launch after 3rd vblank", base + 1, 10);
    bus_write(3'd0, 32'h2);
    wait_cycles(40);
    disp_q.push_back(1'b1);
    pulse_vb();
    wait_cycles(5);
    repeat (4) begin pulse_vb(); wait_cycles(5); end
    check("step ran one generation", 32'(starts_seen), 32'(base + 1));
    rd_check("step GEN_COUNT", 3'd3, 32'd1);
    rd_check("step STATUS", 3'd1, 32'h08);

    // Coincident done and vblank: swap waits for a later vblank.
    done_delay = 0;
    bus_write(3'd4, 32'd0);
    src_q.push_back(1'b1);
    bus_write(3'd0, 32'h2);
    wait_starts("coincident launch", base + 2, 20);
    wait_cycles(3);
    @(posedge clk); #1; done_man = 1'b1; vb_man = 1'b1;
    @(posedge clk); #1; done_man = 1'b0; vb_man = 1'b0;
    wait_cycles(5);
    check("no swap on coincident vblank", 32'(disp_sel), 32'd1);
    rd_check("coincident STATUS", 3'd1, 32'h0C);
    disp_q.push_back(1'b0);
    pulse_vb();
    wait_cycles(3);
    check("swap on later vblank", 32'(disp_q.size()), 32'd0);
    rd_check("coincident GEN_COUNT", 3'd3, 32'd2);

    // Seed write during COMPUTE is dropped.
    src_q.push_back(1'b0);
    bus_write(3'd0, 32'h2);
    wait_starts("seed-err launch", base + 3, 20);
    bus_write(3'd6, 32'h0005_5555);
    wait_cycles(3);
    rd_check("seed err STATUS", 3'd1, 32'h13);
    rd_check("SEED_ADDR unchanged", 3'd5, 32'h0);
    pulse_done();
    disp_q.push_back(1'b1);
    pulse_vb();
    wait_cycles(3);
    rd_check("seed err GEN_COUNT", 3'd3, 32'd3);

    // Reset in the middle of a generation.
    src_q.push_back(1'b1);
    bus_write(3'd0, 32'h2);
    wait_starts("pre-reset launch", base + 4, 20);
    wait_cycles(3);
    reset = 1'b1;
    #1;
    check("async rst disp_sel", 32'(disp_sel), 32'd0);
    check("async rst accel_start", 32'(accel_start), 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    rd_check("post-reset GEN_COUNT", 3'd3, 32'd0);
    rd_check("post-reset STATUS", 3'd1, 32'h0);

`ifdef CONWAY_SCHED_WDOG_EN
    // Watchdog: accel_done never arrives.
    src_q.push_back(1'b0);
    bus_write(3'd0, 32'h3);
    wait_starts("wdog launch", base + 5, 20);
    d = 0;
    while (clears_seen == 0 && d < 400) begin
      @(negedge clk);
      d++;
    end
    check("accel_clear seen", 32'(clears_seen), 32'd1);
    check("accel_clear delay", 32'(clear_cyc - start_cyc), 32'd255);
    wait_cycles(3);
    rd_check("wdog STATUS", 3'd1, 32'h20);
    rd_check("wdog GEN_COUNT", 3'd3, 32'd0);
    rd_check("wdog CTRL", 3'd0, 32'h0);
`endif

    wait_cycles(5);
    check("src queue empty", 32'(src_q.size()), 32'd0);
    check("disp queue empty", 32'(disp_q.size()), 32'd0);
    check("seed queue empty", 32'(seed_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
